instruction_message_scroller: RTL
=================================

# instruction_message_scroller

- Producer side of the packed 40-bit character bus read by the seven-segment display driver.
- Accepts a message of 5-bit character codes over a valid/ready stream and buffers it.
- Scrolls the message right-to-left across the 8-digit window at a programmable step rate.
- Drives the packed `instruction` word consumed by the display multiplexer.

## Interface
- `MSG_MAX`, 16: message buffer depth in characters (2..32).
- `TICK_DIV`, 25_000_000: clock cycles per scroll step (≥2).
- `clk`  in  1  system clock, all logic on rising edge.
- `rst_n`  in  1  synchronous active-low reset. One clock; reset is synchronous and active-low.
- `wr_valid`  in  1  character beat valid.
- `wr_char`  in  5  character code: 0 = blank, 1..26 = glyphs.
- `wr_last`  in  1  marks final beat of message.
- `wr_ready`  out  1  beat accepted when `wr_valid && wr_ready` at rising edge.
- `clear`  in  1  abort: discard message, blank display.
- `instruction`  out  40  packed digits. Digit 7 (leftmost) = [39:35], digit 0 = [4:0].
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse at end of each scroll pass.

## Operation
- States: IDLE, LOAD, SCROLL.
- IDLE → LOAD on the first accepted beat; IDLE → SCROLL directly if that beat also has `wr_last`.
- LOAD → SCROLL on the accepted beat with `wr_last`.
- `wr_ready = (state==IDLE || state==LOAD) && !clear`, combinational.
- Each accepted beat writes `buf[len]` and increments `len`.
- Codes 27..31 are stored as 0 (blank).
- Overflow: beats beyond `MSG_MAX` are still accepted but dropped; `len` saturates at `MSG_MAX`.
- Scrolling: on each step, `instruction <= {instruction[34:0], next}`.
  - `next = buf[idx]` if `idx < len`, else 0; then `idx` increments.
  - A pass is `len + 8` steps, so the message fully exits and the display ends blank.
- After the final step of a pass:
  - `done` pulses.
  - `idx` and the tick counter clear.
  - State → IDLE; `len` clears (wrap behaviour per Configuration).
- `clear` is honoured in any state, with priority over beats and steps.
  - Next edge: state IDLE, `instruction = 0`, `len = 0`, `idx = 0`, tick counter 0, no `done`.
- `clear` together with `wr_valid`: beat is not accepted.
- Reset mid-operation has the same effect as `clear`. A reset-time `done` is suppressed.

## Timing
- Reset values: state IDLE, `instruction = 0`, `busy = 0`, `done = 0`, `len = idx = 0`, tick counter 0.
- `wr_ready` is 0 while `rst_n = 0` and 1 on the first cycle after reset.
- Tick counter runs only in SCROLL, counting 0..TICK_DIV-1 and stepping when it equals TICK_DIV-1.
- The first step occurs TICK_DIV cycles after the edge that enters SCROLL.
- `done` is asserted in the cycle following the final step edge, for exactly one cycle.
- `busy` falls on the same edge that raises `done` when not wrapping.
- `instruction` is registered and changes only on step edges, `clear`, or reset.

## Configuration
- Macro `SCROLL_WRAP_EN`.
- Defined: at end of a pass, state stays SCROLL.
  - `idx` restarts at 0, `len` and `buf` are retained, and the next pass begins seamlessly.
  - `done` pulses once per pass; `busy` stays high until `clear` or reset.
  - `wr_ready` stays low throughout.
- Undefined: single pass, then return to IDLE as described in Operation.

## Structure
- Package `instr_disp_pkg`:
  - `CHAR_W = 5`, `DIGITS = 8`, `CODE_BLANK = 0`, `CODE_MAX = 26`.
  - State enum `scroll_state_t` {IDLE, LOAD, SCROLL}.
  - Shared with the display driver for code definitions.
- Sub-module `scroll_tick_gen`: parameterised by `TICK_DIV`; inputs `clk`, `rst_n`, `en`, `clr`; output `tick` (1-cycle pulse).
- Top level holds the FSM, character buffer, `len`/`idx` counters and the shift register.

## Test plan
All tests use `TICK_DIV=4`, `MSG_MAX=16`.
- Reset check: hold `rst_n=0` for 3 cycles → `instruction=0`, `busy=0`, `done=0`, `wr_ready=0`; release → `wr_ready=1`.
- Two-character message: load codes 1, 2 with `wr_last` on 2.
  - Step 1 (4 cycles later): `instruction=0x1`.
  - Step 2: `instruction=0x22`.
  - After step 10: `instruction=0`, `done` pulses once, `busy=0`.
- Overflow: stream 20 beats of code 5 with `wr_last` on the 20th → all accepted, `len=16`, `done` after step 24, never more than 16 nonzero digits shifted in.
- Invalid code: load single beat code 30 with `wr_last` → step 1 gives `instruction=0`; `done` after step 9.
- Abort: `clear` during step 3 of a 4-character pass → next edge `instruction=0`, `busy=0`, no `done`; `clear` coincident with `wr_valid` → beat not accepted.
- With `SCROLL_WRAP_EN`: load codes 1, 2 → `done` at steps 10, 20 and 30; step 11 gives `instruction=0x1`; `busy` stays 1 until `clear`.

Source files
------------

// File: rtl/instr_disp_pkg.sv
// Shared character-code and state definitions for the message scroller and seven-segment driver.
// Code 0 is blank, 1..26 are glyphs; anything above CODE_MAX is displayed as blank.
package instr_disp_pkg;

    localparam int CHAR_W = 5;
    localparam int DIGITS = 8;
    localparam int INSTR_W = CHAR_W * DIGITS;

    localparam logic [CHAR_W-1:0] CODE_BLANK = 5'd0;
    localparam logic [CHAR_W-1:0] CODE_MAX   = 5'd26;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        SCROLL = 2'd2
    } scroll_state_t;

    function automatic logic [CHAR_W-1:0] sanitize_code(input logic [CHAR_W-1:0] code);
        return (code > CODE_MAX) ? CODE_BLANK : code;
    endfunction

endpackage

// File: rtl/scroll_tick_gen.sv
// Scroll step strobe: counts 0..TICK_DIV-1 while enabled and pulses tick on the last count.
// Held at zero whenever disabled or cleared so every scroll phase starts from a fresh period.
module scroll_tick_gen #(
    parameter int TICK_DIV = 25_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr || !en) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign tick = en && !clr && (cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/instruction_message_scroller.sv
// Buffers a streamed message and scrolls it right-to-left across the 8-digit packed instruction bus.
// Optional macro SCROLL_WRAP_EN: repeat the message pass indefinitely instead of returning to IDLE.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | empty buffer, waiting for the first character beat
// LOAD   | accepting further beats until the one marked wr_last
// SCROLL | shifting one character into digit 0 on every tick
module instruction_message_scroller
    import instr_disp_pkg::*;
#(
    parameter int MSG_MAX  = 16,
    parameter int TICK_DIV = 25_000_000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_valid,
    input  logic [CHAR_W-1:0]  wr_char,
    input  logic               wr_last,
    output logic               wr_ready,
    input  logic               clear,
    output logic [INSTR_W-1:0] instruction,
    output logic               busy,
    output logic               done
);

    localparam int LEN_W  = $clog2(MSG_MAX + 1);
    localparam int IDX_W  = $clog2(MSG_MAX + DIGITS);
    localparam int BUF_AW = $clog2(MSG_MAX);

    scroll_state_t      state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               done_q, done_d;
    logic [CHAR_W-1:0]  msg_buf_q [MSG_MAX];
    logic [CHAR_W-1:0]  msg_buf_d [MSG_MAX];

    logic               beat_acc;
    logic               step;
    logic               last_step;
    logic [CHAR_W-1:0]  next_char;
    logic [BUF_AW-1:0]  wr_ptr;
    logic [BUF_AW-1:0]  rd_ptr;

    scroll_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (state_q == SCROLL),
        .clr  (clear),
        .tick (step)
    );

    // Gated by rst_n so the stream sees no ready while reset is held.
    assign wr_ready = rst_n && !clear && ((state_q == IDLE) || (state_q == LOAD));
    assign beat_acc = wr_valid && wr_ready;

    assign wr_ptr    = BUF_AW'(len_q);
    assign rd_ptr    = BUF_AW'(idx_q);
    assign next_char = (idx_q < IDX_W'(len_q)) ? msg_buf_q[rd_ptr] : CODE_BLANK;
    assign last_step = (idx_q == (IDX_W'(len_q) + IDX_W'(DIGITS - 1)));

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        idx_d     = idx_q;
        instr_d   = instr_q;
        done_d    = 1'b0;
        msg_buf_d = msg_buf_q;

        if (clear) begin
            state_d = IDLE;
            len_d   = '0;
            idx_d   = '0;
            instr_d = '0;
        end else begin
            if (beat_acc) begin
                // Beats past the buffer depth are still consumed so the stream never stalls.
                if (len_q < LEN_W'(MSG_MAX)) begin
                    msg_buf_d[wr_ptr] = sanitize_code(wr_char);
                    len_d             = len_q + LEN_W'(1);
                end
                state_d = wr_last ? SCROLL : LOAD;
            end

            if (step) begin
                instr_d = {instr_q[INSTR_W-CHAR_W-1:0], next_char};
                idx_d   = idx_q + IDX_W'(1);
                if (last_step) begin
                    done_d = 1'b1;
                    idx_d  = '0;
`ifdef SCROLL_WRAP_EN
                    state_d = SCROLL;
`else
                    state_d = IDLE;
                    len_d   = '0;
`endif
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            instr_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            instr_q <= instr_d;
            done_q  <= done_d;
        end
    end

    // Buffer contents are only meaningful below len, so they need no reset.
    always_ff @(posedge clk) begin
        msg_buf_q <= msg_buf_d;
    end

    assign instruction = instr_q;
    assign busy        = (state_q != IDLE);
    assign done        = done_q;

endmodule
